mul_ctrl: RTL and testbench
===========================

# mul_ctrl

Sequencing controller between the EX stage and the iterative 32x32 multiplier. It accepts MULT/MULTU/MADD/MSUB from EX and latches operands. It holds the multiplier's start level for the whole operation and stalls the pipeline until the product is back. For accumulate ops it adds or subtracts the product against HI/LO, then issues a single-cycle HI/LO write.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- valid_i  in  1  EX holds a multiply-class instruction
- op_i  in  2  00 MULT (signed), 01 MULTU, 10 MADD (signed, HI/LO += prod), 11 MSUB (signed, HI/LO -= prod)
- src1_i, src2_i  in  32  operands
- hi_i, lo_i  in  32  current HI/LO, with forwarding already applied
- flush_i  in  1  pipeline flush; kills the in-flight op
- mul_start_o  out  1  multiplier start level
- mul_signed_o  out  1  multiplier signed select
- mul_op1_o, mul_op2_o  out  32  latched operands to the multiplier
- mul_annul_o  out  1  multiplier annul
- mul_result_i  in  64  multiplier product
- mul_ready_i  in  1  multiplier done
- stallreq_o  out  1  stall request to the pipeline controller
- hilo_we_o  out  1  HI/LO write enable, one-cycle pulse
- hi_o, lo_o  out  32  HI/LO write data

## Operation
- States: IDLE, RUN, ACC, DONE.
- IDLE:
  - On valid_i && !flush_i: latch op_i, src1_i, src2_i, hi_i, lo_i; go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - mul_start_o=1 and mul_signed_o=(op!=01) are driven from registered state. They stay stable for the whole of RUN.
  - On mul_ready_i: latch mul_result_i into prod. Go to ACC if op[1]=1, else go to DONE.
- ACC (one cycle): acc = {hi,lo} + prod for MADD, or {hi,lo} - prod for MSUB. Arithmetic is 64-bit modulo 2^64; carry/borrow out is discarded. Go to DONE.
- DONE (one cycle):
  - hilo_we_o=1.
  - {hi_o,lo_o} = prod for MULT/MULTU, acc for MADD/MSUB.
  - mul_start_o=0, which releases the multiplier back to its idle state.
  - Next state is IDLE.
- stallreq_o is combinational: 1 when (IDLE && valid_i && !flush_i), in RUN, or in ACC; 0 in DONE. The pipeline therefore advances at the end of DONE, and the next valid_i is seen in IDLE.
- Flush:
  - flush_i in RUN or ACC: go to IDLE next cycle; mul_start_o=0; mul_annul_o=1 for exactly that one cycle; no HI/LO write.
  - flush_i in DONE: the write still completes, because the op has already retired.
  - flush_i in IDLE: a pending valid_i is ignored.
- mul_result_i is sampled only while mul_ready_i=1 in RUN. mul_ready_i outside RUN is ignored.
- Zero operands need no special handling: the multiplier's fast path returns ready early, and the controller waits on ready regardless of latency.
- Reset, including mid-operation:
  - State goes to IDLE and all outputs go to 0.
  - mul_start_o drops on the first reset cycle, which also clears the multiplier.

## Timing
- Cycle 0: IDLE with valid_i, stallreq_o=1 combinationally.
- Cycle 1: RUN, mul_start_o=1.
- Cycle k: first cycle with mul_ready_i=1 in RUN.
- Cycle k+1: DONE, or ACC then DONE at k+2.
- Total stall = (DONE cycle) - 0 cycles; the instruction leaves EX at the end of DONE.
- hilo_we_o is high for exactly one cycle per completed op; never two writes per op.
- mul_op1_o, mul_op2_o and mul_signed_o are constant from RUN entry until DONE.
- Back-to-back ops: the second op enters RUN no earlier than 2 cycles after DONE (DONE → IDLE → RUN). This guarantees mul_start_o is low for at least 1 cycle between ops.

## Configuration
- MUL_ACC_EN defined: MADD/MSUB are supported and the ACC state and accumulator are present.
- MUL_ACC_EN undefined:
  - ACC state, acc register and hi_i/lo_i latching are removed.
  - op_i=10/11 is treated as not accepted: no stall, no start, no write. The FSM stays in IDLE.
  - MULT/MULTU behaviour is unchanged.

## Test plan
- MULT, src1=0xFFFFFFFE (-2), src2=3 → one hilo_we_o pulse with hi=0xFFFFFFFF, lo=0xFFFFFFFA; stallreq_o falls exactly in the DONE cycle.
- MULTU, src1=0xFFFFFFFF, src2=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; mul_signed_o=0 throughout RUN.
- MADD, HI/LO=0x00000000_FFFFFFFF, src1=1, src2=1 → hi=0x00000001, lo=0x00000000 (carry into HI). MSUB with HI/LO=0, src1=1, src2=1 → hi=lo=0xFFFFFFFF (wrap).
- MULT, src1=0, src2=5 → multiplier fast path; result 0 and a single write; the stall is shorter than for nonzero operands.
- flush_i asserted 10 cycles into RUN → mul_annul_o pulses once and mul_start_o drops the next cycle; no hilo_we_o. A following MULT 7*6 completes with lo=42.
- rst asserted mid-RUN → all outputs are 0 on the next edge. Without MUL_ACC_EN, op_i=10 with valid_i → stallreq_o=0 and no start.

Source files
------------

// File: rtl/mul_ctrl_if.sv
// Bundles the EX-side request, the iterative multiplier handshake and the HI/LO write port of mul_ctrl.
// master = the controller; slave = the pipeline/multiplier environment around it.
interface mul_ctrl_if;
    logic        valid_i;
    logic [1:0]  op_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic        flush_i;

    logic        mul_start_o;
    logic        mul_signed_o;
    logic [31:0] mul_op1_o;
    logic [31:0] mul_op2_o;
    logic        mul_annul_o;
    logic [63:0] mul_result_i;
    logic        mul_ready_i;

    logic        stallreq_o;
    logic        hilo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        input  valid_i, op_i, src1_i, src2_i, hi_i, lo_i, flush_i,
        input  mul_result_i, mul_ready_i,
        output mul_start_o, mul_signed_o, mul_op1_o, mul_op2_o, mul_annul_o,
        output stallreq_o, hilo_we_o, hi_o, lo_o
    );

    modport slave (
        output valid_i, op_i, src1_i, src2_i, hi_i, lo_i, flush_i,
        output mul_result_i, mul_ready_i,
        input  mul_start_o, mul_signed_o, mul_op1_o, mul_op2_o, mul_annul_o,
        input  stallreq_o, hilo_we_o, hi_o, lo_o
    );
endinterface

// File: rtl/mul_ctrl.sv
// Sequences one MULT/MULTU (and MADD/MSUB when MUL_ACC_EN is defined) through the iterative
// multiplier, stalling EX from acceptance until the single-cycle HI/LO write in DONE.
module mul_ctrl (
    input  logic       clk,
    input  logic       rst,
    mul_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_ACC  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e      state_q;
    state_e      state_d;
    logic        signed_q;
    logic [31:0] op1_q;
    logic [31:0] op2_q;
    logic [63:0] prod_q;
    logic        annul_q;
    logic        op_ok;
    logic        accept;
    logic        kill;

`ifdef MUL_ACC_EN
    logic [1:0]  op_q;
    logic [63:0] hilo_q;
    logic [63:0] acc_q;

    assign op_ok = 1'b1;
`else
    logic        unused_hilo;

    // Accumulate ops are refused outright so EX never stalls on them.
    assign op_ok       = ~bus.op_i[1];
    assign unused_hilo = ^{bus.hi_i, bus.lo_i};
`endif

    assign accept = (state_q == S_IDLE) && bus.valid_i && !bus.flush_i && op_ok;
    assign kill   = ((state_q == S_RUN) || (state_q == S_ACC)) && bus.flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.flush_i) begin
                    state_d = S_IDLE;
                end else if (bus.mul_ready_i) begin
`ifdef MUL_ACC_EN
                    state_d = op_q[1] ? S_ACC : S_DONE;
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_ACC: begin
                state_d = bus.flush_i ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                // Already retired: a flush here cannot cancel the write.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            signed_q <= 1'b0;
            op1_q    <= 32'h0;
            op2_q    <= 32'h0;
            prod_q   <= 64'h0;
            annul_q  <= 1'b0;
`ifdef MUL_ACC_EN
            op_q     <= 2'b00;
            hilo_q   <= 64'h0;
            acc_q    <= 64'h0;
`endif
        end else begin
            annul_q <= kill;
            if (accept) begin
                signed_q <= (bus.op_i != 2'b01);
                op1_q    <= bus.src1_i;
                op2_q    <= bus.src2_i;
`ifdef MUL_ACC_EN
                op_q     <= bus.op_i;
                hilo_q   <= {bus.hi_i, bus.lo_i};
`endif
            end else if (kill || (state_q == S_DONE)) begin
                signed_q <= 1'b0;
            end
            if ((state_q == S_RUN) && bus.mul_ready_i && !bus.flush_i) begin
                prod_q <= bus.mul_result_i;
            end
`ifdef MUL_ACC_EN
            // Modulo 2^64: carry/borrow out of HI is dropped.
            if ((state_q == S_ACC) && !bus.flush_i) begin
                acc_q <= op_q[0] ? (hilo_q - prod_q) : (hilo_q + prod_q);
            end
`endif
        end
    end

    always_comb begin
        bus.mul_start_o  = 1'b0;
        bus.stallreq_o   = 1'b0;
        bus.hilo_we_o    = 1'b0;
        bus.hi_o         = 32'h0;
        bus.lo_o         = 32'h0;
        bus.mul_signed_o = signed_q;
        bus.mul_op1_o    = op1_q;
        bus.mul_op2_o    = op2_q;
        bus.mul_annul_o  = annul_q;
        case (state_q)
            S_IDLE: begin
                bus.stallreq_o = accept;
            end
            S_RUN, S_ACC: begin
                bus.mul_start_o = 1'b1;
                bus.stallreq_o  = 1'b1;
            end
            S_DONE: begin
                bus.hilo_we_o = 1'b1;
`ifdef MUL_ACC_EN
                {bus.hi_o, bus.lo_o} = op_q[1] ? acc_q : prod_q;
`else
                {bus.hi_o, bus.lo_o} = prod_q;
`endif
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl with a behavioural iterative multiplier of programmable latency.
module tb_mul_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   lat    = 4;
    int   mcnt   = 0;

    always #5 clk = ~clk;

    mul_ctrl_if bus ();

    mul_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [63:0] mprod(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = s ? {{32{a[31]}}, a} : {32'h0, a};
        eb = s ? {{32{b[31]}}, b} : {32'h0, b};
        return ea * eb;
    endfunction

    // Multiplier: ready rises 'lat' cycles after start and holds until start drops.
    always @(negedge clk) begin
        if (bus.mul_start_o && !bus.mul_annul_o) begin
            mcnt = mcnt + 1;
            if (mcnt >= lat) begin
                bus.mul_ready_i  = 1'b1;
                bus.mul_result_i = mprod(bus.mul_signed_o, bus.mul_op1_o, bus.mul_op2_o);
            end else begin
                bus.mul_ready_i  = 1'b0;
                bus.mul_result_i = 64'h0;
            end
        end else begin
            mcnt             = 0;
            bus.mul_ready_i  = 1'b0;
            bus.mul_result_i = 64'h0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] h, input logic [31:0] l,
                          input int latency, input logic [31:0] eh, input logic [31:0] el,
                          input int estall, input logic esigned);
        int   cyc;
        logic done;
        lat         = latency;
        bus.valid_i = 1'b1;
        bus.op_i    = op;
        bus.src1_i  = a;
        bus.src2_i  = b;
        bus.hi_i    = h;
        bus.lo_i    = l;
        #1;
        check({tag, ".stall_c0"}, 64'(bus.stallreq_o), 64'h1);
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 100) begin
            tick();
            cyc = cyc + 1;
            if (cyc == 1) begin
                check({tag, ".run_start"}, 64'({bus.mul_start_o, bus.mul_signed_o}), 64'({1'b1, esigned}));
                check({tag, ".run_ops"}, {bus.mul_op1_o, bus.mul_op2_o}, {a, b});
            end
            if (bus.hilo_we_o) begin
                done = 1'b1;
                check({tag, ".done_stall"}, 64'({bus.stallreq_o, bus.mul_start_o}), 64'h0);
                check({tag, ".hilo"}, {bus.hi_o, bus.lo_o}, {eh, el});
                check({tag, ".stall_len"}, 64'(cyc), 64'(estall));
                check({tag, ".done_ops"}, {bus.mul_op1_o, bus.mul_op2_o}, {a, b});
            end
        end
        if (!done) begin
            check({tag, ".timeout"}, 64'h0, 64'h1);
        end
        tick();
        bus.valid_i = 1'b0;
        #1;
        check({tag, ".single_write"}, 64'(bus.hilo_we_o), 64'h0);
    endtask

    initial begin
        int writes;
        rst              = 1'b1;
        bus.valid_i      = 1'b0;
        bus.op_i         = 2'b00;
        bus.src1_i       = 32'h0;
        bus.src2_i       = 32'h0;
        bus.hi_i         = 32'h0;
        bus.lo_i         = 32'h0;
        bus.flush_i      = 1'b0;
        bus.mul_ready_i  = 1'b0;
        bus.mul_result_i = 64'h0;
        tick();
        tick();
        check("reset.ctl", 64'({bus.mul_start_o, bus.mul_signed_o, bus.mul_annul_o,
                                bus.stallreq_o, bus.hilo_we_o}), 64'h0);
        check("reset.data", {bus.hi_o, bus.lo_o}, 64'h0);
        rst = 1'b0;
        tick();

        run_op("mult_neg", 2'b00, 32'hFFFF_FFFE, 32'h3, 32'h0, 32'h0, 4,
               32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 1'b1);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 4,
               32'hFFFF_FFFE, 32'h0000_0001, 5, 1'b0);
`ifdef MUL_ACC_EN
        run_op("madd_carry", 2'b10, 32'h1, 32'h1, 32'h0, 32'hFFFF_FFFF, 4,
               32'h1, 32'h0, 6, 1'b1);
        run_op("msub_wrap", 2'b11, 32'h1, 32'h1, 32'h0, 32'h0, 4,
               32'hFFFF_FFFF, 32'hFFFF_FFFF, 6, 1'b1);
`endif
        run_op("mult_zero", 2'b00, 32'h0, 32'h5, 32'h0, 32'h0, 1,
               32'h0, 32'h0, 2, 1'b1);

        // Flush ten cycles into a long-running MULT.
        lat         = 40;
        bus.valid_i = 1'b1;
        bus.op_i    = 2'b00;
        bus.src1_i  = 32'h9;
        bus.src2_i  = 32'h9;
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        bus.flush_i = 1'b1;
        bus.valid_i = 1'b0;
        tick();
        bus.flush_i = 1'b0;
        check("flush.annul", 64'({bus.mul_annul_o, bus.mul_start_o, bus.hilo_we_o}), 64'b100);
        writes = 0;
        tick();
        check("flush.annul_once", 64'(bus.mul_annul_o), 64'h0);
        for (int i = 0; i < 45; i++) begin
            if (bus.hilo_we_o) writes = writes + 1;
            tick();
        end
        check("flush.no_write", 64'(writes), 64'h0);
        run_op("mult_after_flush", 2'b00, 32'h7, 32'h6, 32'h0, 32'h0, 4,
               32'h0, 32'd42, 5, 1'b1);

        // Synchronous reset in the middle of RUN.
        lat         = 40;
        bus.valid_i = 1'b1;
        bus.op_i    = 2'b01;
        bus.src1_i  = 32'h3;
        bus.src2_i  = 32'h4;
        tick();
        tick();
        check("rstmid.pre", 64'(bus.mul_start_o), 64'h1);
        rst         = 1'b1;
        bus.valid_i = 1'b0;
        tick();
        check("rstmid.ctl", 64'({bus.mul_start_o, bus.mul_signed_o, bus.mul_annul_o,
                                 bus.stallreq_o, bus.hilo_we_o}), 64'h0);
        check("rstmid.ops", {bus.mul_op1_o, bus.mul_op2_o}, 64'h0);
        check("rstmid.hilo", {bus.hi_o, bus.lo_o}, 64'h0);
        rst = 1'b0;
        tick();

`ifndef MUL_ACC_EN
        // Accumulate op is not accepted in this build.
        bus.valid_i = 1'b1;
        bus.op_i    = 2'b10;
        bus.src1_i  = 32'h2;
        bus.src2_i  = 32'h2;
        #1;
        check("noacc.stall", 64'(bus.stallreq_o), 64'h0);
        tick();
        check("noacc.start", 64'({bus.mul_start_o, bus.stallreq_o}), 64'h0);
        tick();
        check("noacc.write", 64'({bus.hilo_we_o, bus.mul_start_o}), 64'h0);
        bus.valid_i = 1'b0;
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
